// File: rtl/move_cmd_encoder_if.sv
// Move command handshake bundle between the button encoder and the game FSM.
//   move_valid  encoder -> game  a move is presented on the direction bits
//   move_ready  game -> encoder  game accepts the move this cycle
//   up/down/left/right  encoder -> game  one-hot direction, zero when idle
//   drop_count  encoder -> game  saturating count of presses lost while busy
// master: the encoder side; slave: the game FSM side.
interface move_cmd_encoder_if #(
    parameter int DROP_W = 8
);
    logic              move_valid;
    logic              move_ready;
    logic              up;
    logic              down;
    logic              left;
    logic              right;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output move_valid, up, down, left, right, drop_count,
        input  move_ready
    );

    modport slave (
        input  move_valid, up, down, left, right, drop_count,
        output move_ready
    );
endinterface

// File: rtl/move_cmd_encoder.sv
// Turns four raw push-buttons into one move command per physical press for the
// 2048 game FSM. Each button is synchronised (2 flops), debounced and
// edge-detected; simultaneous presses are arbitrated right > left > up > down
// and the winner is offered through a valid/ready handshake.
// Ports:
//   Clk      system clock, all logic on posedge
//   Reset_n  asynchronous active-low reset
//   BtnU/BtnD/BtnL/BtnR  raw asynchronous active-high buttons
//   mv       move handshake bundle (master side), see move_cmd_encoder_if
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for a debounced press
// ST_PENDING | move presented, held until move_valid & move_ready
// ST_RELEASE | move taken, waiting for every button to be released
module move_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DROP_W          = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                BtnU,
    input  logic                BtnD,
    input  logic                BtnL,
    input  logic                BtnR,
    move_cmd_encoder_if.master  mv
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Button vector order: [0]=up [1]=down [2]=left [3]=right
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    logic [3:0]       btn_raw;
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       db_lvl;
    logic [3:0]       db_lvl_d;
    logic [3:0]       press;

    state_t            state;
    logic              valid_q;
    logic [3:0]        dir_q;
    logic [DROP_W-1:0] drop_q;

    assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // The counter tracks consecutive samples disagreeing with the accepted
    // level; any agreeing sample restarts the count, so short glitches vanish.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            db_lvl   <= '0;
            db_lvl_d <= '0;
        end else begin
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_lvl[i] <= ~db_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_lvl & ~db_lvl_d;

    function automatic logic [3:0] pick_dir(input logic [3:0] p);
        logic [3:0] onehot;
        onehot = '0;
        if (p[B_RIGHT]) begin
            onehot[B_RIGHT] = 1'b1;
        end else if (p[B_LEFT]) begin
            onehot[B_LEFT] = 1'b1;
        end else if (p[B_UP]) begin
            onehot[B_UP] = 1'b1;
        end else if (p[B_DOWN]) begin
            onehot[B_DOWN] = 1'b1;
        end
        return onehot;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            dir_q   <= '0;
            drop_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        state   <= ST_PENDING;
                        valid_q <= 1'b1;
                        dir_q   <= pick_dir(press);
                    end
                end
                ST_PENDING: begin
                    if ((|press) && (drop_q != DROP_MAX)) begin
                        drop_q <= drop_q + DROP_W'(1);
                    end
                    // valid_q is always 1 here, so move_ready alone completes it
                    if (mv.move_ready) begin
                        state   <= ST_RELEASE;
                        valid_q <= 1'b0;
                        dir_q   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if ((|press) && (drop_q != DROP_MAX)) begin
                        drop_q <= drop_q + DROP_W'(1);
                    end
                    if (db_lvl == 4'b0000) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    dir_q   <= '0;
                end
            endcase
        end
    end

    assign mv.move_valid = valid_q;
    assign mv.up         = dir_q[B_UP];
    assign mv.down       = dir_q[B_DOWN];
    assign mv.left       = dir_q[B_LEFT];
    assign mv.right      = dir_q[B_RIGHT];
    assign mv.drop_count = drop_q;

endmodule

// File: tb/tb_move_cmd_encoder.sv
// Bench for move_cmd_encoder: directed button scenarios with literal
// expectations, plus a history-window behavioural model compared every cycle.
module tb_move_cmd_encoder;
    localparam int DB       = 4;
    localparam int DW       = 8;
    localparam int DROP_SAT = (1 << DW) - 1;
    localparam int ORD [4]  = '{3, 2, 0, 1};

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;

    int checks   = 0;
    int failures = 0;
    int n_moves;

    move_cmd_encoder_if #(.DROP_W(DW)) mv();

    move_cmd_encoder #(.DEBOUNCE_CYCLES(DB), .DROP_W(DW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .BtnU    (BtnU),
        .BtnD    (BtnD),
        .BtnL    (BtnL),
        .BtnR    (BtnR),
        .mv      (mv)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a button's accepted level flips once its last DB synchronised
    // samples all disagree with it; a rise becomes a press one edge later.
    logic [3:0]    m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_dir = '0;
    logic [DB-1:0] m_hist [4] = '{default: '0};
    int            m_mode = 0;
    logic          m_valid = 1'b0;
    int            m_drop = 0;

    logic [3:0]    t_nl, t_dir;
    logic [DB-1:0] t_h;
    int            t_mode, t_drop;
    logic          t_valid;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_press <= '0;
            m_dir <= '0; m_mode <= 0; m_valid <= 1'b0; m_drop <= 0;
            for (int i = 0; i < 4; i++) m_hist[i] <= '0;
        end else begin
            t_mode = m_mode; t_valid = m_valid; t_dir = m_dir; t_drop = m_drop;
            if (m_mode == 0) begin
                if (m_press != 0) begin
                    t_mode = 1; t_valid = 1'b1; t_dir = '0;
                    for (int j = 0; j < 4; j++)
                        if (t_dir == 0 && m_press[ORD[j]]) t_dir[ORD[j]] = 1'b1;
                end
            end else begin
                if (m_press != 0 && m_drop < DROP_SAT) t_drop = m_drop + 1;
                if (m_mode == 1) begin
                    if (mv.move_ready) begin t_mode = 2; t_valid = 1'b0; t_dir = '0; end
                end else if (m_lvl == 0) begin
                    t_mode = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                t_h = {m_hist[i][DB-2:0], m_s2[i]};
                m_hist[i] <= t_h;
                t_nl[i] = (t_h == {DB{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
            end
            m_press <= t_nl & ~m_lvl;
            m_lvl   <= t_nl;
            m_s2    <= m_s1;
            m_s1    <= {BtnR, BtnL, BtnD, BtnU};
            m_mode  <= t_mode; m_valid <= t_valid; m_dir <= t_dir; m_drop <= t_drop;
        end
    end

    always @(negedge Clk) begin
        chk("cmp_valid", int'(mv.move_valid), int'(m_valid));
        chk("cmp_dir", int'({mv.right, mv.left, mv.down, mv.up}), int'(m_dir));
        chk("cmp_drop", int'(mv.drop_count), m_drop);
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mv.move_ready = 1'b0;
        // 1: reset with toggling buttons
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            {BtnR, BtnL, BtnD, BtnU} = 4'(i * 5 + 3);
        end
        chk("rst_valid", int'(mv.move_valid), 0);
        chk("rst_dir", int'({mv.right, mv.left, mv.down, mv.up}), 0);
        chk("rst_drop", int'(mv.drop_count), 0);
        @(negedge Clk);
        {BtnR, BtnL, BtnD, BtnU} = 4'b0000;
        Reset_n = 1'b1;
        ticks(15);
        chk("idle_no_move", int'(mv.move_valid), 0);

        // 2: up press, latency and single issue while held
        mv.move_ready = 1'b1;
        BtnU = 1'b1;
        ticks(6);
        chk("up_lat_early", int'(mv.move_valid), 0);
        ticks(1);
        chk("up_valid", int'(mv.move_valid), 1);
        chk("up_dir", int'(mv.up), 1);
        ticks(1);
        chk("up_one_cycle", int'(mv.move_valid), 0);
        n_moves = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (mv.move_valid) n_moves++;
        end
        chk("up_no_repeat", n_moves, 0);
        BtnU = 1'b0;
        ticks(12);
        BtnU = 1'b1;
        ticks(7);
        chk("up_second_press", int'(mv.move_valid & mv.up), 1);
        BtnU = 1'b0;
        ticks(12);

        // 3: short glitch rejected, longer pulse accepted once
        BtnL = 1'b1;
        ticks(3);
        BtnL = 1'b0;
        n_moves = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge Clk);
            if (mv.move_valid) n_moves++;
        end
        chk("glitch3_no_move", n_moves, 0);
        BtnL = 1'b1;
        n_moves = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk);
            if (c == 5) BtnL = 1'b0;
            if (mv.move_valid && mv.left) n_moves++;
        end
        chk("glitch6_one_left", n_moves, 1);

        // 4: stalled down move, right press dropped
        mv.move_ready = 1'b0;
        BtnD = 1'b1;
        ticks(7);
        chk("down_valid", int'(mv.move_valid & mv.down), 1);
        BtnR = 1'b1;
        ticks(10);
        chk("down_held", int'({mv.move_valid, mv.right, mv.left, mv.down, mv.up}), 5'b10010);
        chk("drop_one", int'(mv.drop_count), 1);
        mv.move_ready = 1'b1;
        ticks(1);
        chk("down_accepted", int'(mv.move_valid), 0);
        n_moves = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (mv.right) n_moves++;
        end
        chk("never_right", n_moves, 0);
        BtnD = 1'b0; BtnR = 1'b0;
        ticks(12);

        // 5: simultaneous up and right
        BtnU = 1'b1; BtnR = 1'b1;
        ticks(7);
        chk("simul_dir", int'({mv.move_valid, mv.right, mv.left, mv.down, mv.up}), 5'b11000);
        chk("simul_drop", int'(mv.drop_count), 1);
        BtnU = 1'b0; BtnR = 1'b0;
        ticks(12);

        // 6: asynchronous reset while pending
        mv.move_ready = 1'b0;
        BtnU = 1'b1;
        ticks(7);
        chk("pend_valid", int'(mv.move_valid & mv.up), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(mv.move_valid), 0);
        chk("async_rst_up", int'(mv.up), 0);
        chk("async_rst_drop", int'(mv.drop_count), 0);
        #1;
        Reset_n = 1'b1;
        ticks(6);
        chk("rst_lat_early", int'(mv.move_valid), 0);
        ticks(1);
        chk("rst_relatch", int'(mv.move_valid & mv.up), 1);
        mv.move_ready = 1'b1;
        BtnU = 1'b0;
        ticks(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
